// File: rtl/e203_itcm_icb_slave.sv
// ICB responder in front of a 1-cycle-latency single-port ITCM SRAM: response valid the cycle after accept,
// one command per cycle; while a response is stalled cmd_ready drops so the SRAM output is never disturbed.
module e203_itcm_icb_slave #(
   parameter int unsigned AW    = 16,
   parameter int unsigned DW    = 64,
   parameter int unsigned DEPTH = 8192
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      icb_cmd_valid,
   output logic                      icb_cmd_ready,
   input  logic [AW-1:0]             icb_cmd_addr,
   input  logic                      icb_cmd_read,
   input  logic [DW-1:0]             icb_cmd_wdata,
   input  logic [DW/8-1:0]           icb_cmd_wmask,
   output logic                      icb_rsp_valid,
   input  logic                      icb_rsp_ready,
   output logic                      icb_rsp_err,
   output logic [DW-1:0]             icb_rsp_rdata,
   output logic                      holdup,
   output logic                      ram_cs,
   output logic                      ram_we,
   output logic [AW-$clog2(DW/8)-1:0] ram_addr,
   output logic [DW/8-1:0]           ram_wem,
   output logic [DW-1:0]             ram_din,
   input  logic [DW-1:0]             ram_dout
);

   localparam int unsigned OB = $clog2(DW/8);
   localparam int unsigned WW = AW - OB;
   localparam logic [WW:0] DEPTH_L = DEPTH[WW:0];

   logic [WW-1:0] word;
   logic          in_range;
   logic          acc;
   logic          rsp_hsk;
   logic          unused_addr_lsb;

   logic pend_q, pend_d;
   logic pend_err_q, pend_err_d;
   logic pend_rd_q, pend_rd_d;
   logic holdup_q, holdup_d;

   assign word            = icb_cmd_addr[AW-1:OB];
   assign unused_addr_lsb = ^icb_cmd_addr[OB-1:0];
   // Extra MSB so a DEPTH equal to 2^WW still compares correctly.
   assign in_range        = ({1'b0, word} < DEPTH_L);

   assign icb_cmd_ready = rst_n & (~pend_q | icb_rsp_ready);
   assign acc           = icb_cmd_valid & icb_cmd_ready;
   assign rsp_hsk       = pend_q & icb_rsp_ready;

   assign ram_cs   = acc & in_range;
   assign ram_we   = ~icb_cmd_read;
   assign ram_addr = word;
   assign ram_wem  = icb_cmd_wmask;
   assign ram_din  = icb_cmd_wdata;

   always_comb begin
      pend_d     = pend_q;
      pend_err_d = pend_err_q;
      pend_rd_d  = pend_rd_q;
      holdup_d   = holdup_q;
      if (acc) begin
         pend_d     = 1'b1;
         pend_err_d = ~in_range;
         pend_rd_d  = icb_cmd_read & in_range;
      end else if (rsp_hsk) begin
         pend_d = 1'b0;
      end
      // Only a real SRAM access changes what dout holds; errors never touch it.
      if (ram_cs) begin
         holdup_d = ~ram_we;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pend_q     <= 1'b0;
         pend_err_q <= 1'b0;
         pend_rd_q  <= 1'b0;
         holdup_q   <= 1'b0;
      end else begin
         pend_q     <= pend_d;
         pend_err_q <= pend_err_d;
         pend_rd_q  <= pend_rd_d;
         holdup_q   <= holdup_d;
      end
   end

   assign icb_rsp_valid = pend_q;
   assign icb_rsp_err   = pend_err_q;
   assign icb_rsp_rdata = pend_rd_q ? ram_dout : '0;
   assign holdup        = holdup_q;

endmodule

// File: tb/tb_e203_itcm_icb_slave.sv
// Bench for e203_itcm_icb_slave: SRAM model, transaction-level reference model with per-cycle compare,
// and directed scenarios with literal expectations.
module tb_e203_itcm_icb_slave;

   localparam int AW    = 17;
   localparam int DW    = 64;
   localparam int DEPTH = 8192;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          cmd_valid, cmd_ready, cmd_read;
   logic [AW-1:0] cmd_addr;
   logic [63:0]   cmd_wdata;
   logic [7:0]    cmd_wmask;
   logic          rsp_valid, rsp_ready, rsp_err;
   logic [63:0]   rsp_rdata;
   logic          holdup, ram_cs, ram_we;
   logic [13:0]   ram_addr;
   logic [7:0]    ram_wem;
   logic [63:0]   ram_din;
   logic [63:0]   ram_dout;

   int n_chk  = 0;
   int n_fail = 0;
   bit chk_en = 0;

   always #5 clk = ~clk;

   e203_itcm_icb_slave #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .icb_cmd_valid(cmd_valid), .icb_cmd_ready(cmd_ready), .icb_cmd_addr(cmd_addr),
      .icb_cmd_read(cmd_read), .icb_cmd_wdata(cmd_wdata), .icb_cmd_wmask(cmd_wmask),
      .icb_rsp_valid(rsp_valid), .icb_rsp_ready(rsp_ready), .icb_rsp_err(rsp_err),
      .icb_rsp_rdata(rsp_rdata), .holdup(holdup),
      .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wem(ram_wem),
      .ram_din(ram_din), .ram_dout(ram_dout)
   );

   // SRAM macro: 1-cycle read latency, dout held until the next chip select.
   logic [63:0] sram [DEPTH];
   always @(posedge clk) begin
      if (ram_cs) begin
         if (ram_we) begin
            for (int b = 0; b < 8; b++)
               if (ram_wem[b]) sram[ram_addr][b*8 +: 8] <= ram_din[b*8 +: 8];
         end else begin
            ram_dout <= sram[ram_addr];
         end
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference model: one outstanding transaction, memory image updated at accept.
   logic [63:0] ref_mem [DEPTH];
   bit          m_pend = 0, m_err = 0, m_hold = 0;
   logic [63:0] m_rdata = '0;

   function automatic bit addr_ok(input logic [AW-1:0] a);
      return int'(a) / 8 < DEPTH;
   endfunction

   always @(posedge clk) begin
      int w;
      if (!rst_n) begin
         m_pend = 0; m_err = 0; m_hold = 0; m_rdata = '0;
      end else if (cmd_valid && (!m_pend || rsp_ready)) begin
         w      = int'(cmd_addr) / 8;
         m_pend = 1;
         if (!addr_ok(cmd_addr)) begin
            m_err = 1; m_rdata = '0;
         end else if (cmd_read) begin
            m_err = 0; m_rdata = ref_mem[w]; m_hold = 1;
         end else begin
            for (int b = 0; b < 8; b++)
               if (cmd_wmask[b]) ref_mem[w][b*8 +: 8] = cmd_wdata[b*8 +: 8];
            m_err = 0; m_rdata = '0; m_hold = 0;
         end
      end else if (m_pend && rsp_ready) begin
         m_pend = 0;
      end
   end

   always @(negedge clk) begin
      bit exp_rdy, exp_cs;
      if (chk_en) begin
         exp_rdy = rst_n && (!m_pend || rsp_ready);
         exp_cs  = exp_rdy && cmd_valid && addr_ok(cmd_addr);
         chk("m_cmd_ready", 64'(cmd_ready), 64'(exp_rdy));
         chk("m_rsp_valid", 64'(rsp_valid), 64'(m_pend));
         chk("m_holdup", 64'(holdup), 64'(m_hold));
         chk("m_ram_cs", 64'(ram_cs), 64'(exp_cs));
         if (exp_cs) begin
            chk("m_ram_addr", 64'(ram_addr), 64'(int'(cmd_addr) / 8));
            chk("m_ram_we", 64'(ram_we), 64'(!cmd_read));
         end
         if (m_pend) begin
            chk("m_rsp_err", 64'(rsp_err), 64'(m_err));
            chk("m_rsp_rdata", rsp_rdata, m_rdata);
         end
      end
   end

   // Called just after a rising edge; returns just after the accepting edge.
   task automatic send(input bit rd, input logic [AW-1:0] a, input logic [63:0] wd, input logic [7:0] wm);
      bit ok = 0;
      cmd_valid = 1; cmd_read = rd; cmd_addr = a; cmd_wdata = wd; cmd_wmask = wm;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (cmd_ready) begin ok = 1; break; end
         @(posedge clk); #1;
      end
      if (ok) begin @(posedge clk); #1; end
      cmd_valid = 0;
      if (!ok) chk("accept_timeout", 0, 1);
   endtask

   task automatic get_rsp(output logic [63:0] d, output logic e, output int lat);
      bit ok = 0;
      d = '0; e = 0; lat = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (rsp_valid) begin ok = 1; d = rsp_rdata; e = rsp_err; lat = i; break; end
      end
      if (!ok) chk("rsp_timeout", 0, 1);
      @(posedge clk); #1;
   endtask

   localparam logic [63:0] DA = 64'h0123456789ABCDEF;
   localparam logic [63:0] DB = 64'hDEADBEEFCAFEF00D;
   localparam logic [63:0] DC = 64'h1122334455667788;
   localparam logic [63:0] DP = 64'h11223344AAAAAAAA;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [63:0] d;
      logic        e;
      int          lat;
      for (int i = 0; i < DEPTH; i++) begin sram[i] = '0; ref_mem[i] = '0; end
      ram_dout = '0;
      rst_n = 0; rsp_ready = 1;
      cmd_valid = 1; cmd_read = 1; cmd_addr = '0; cmd_wdata = '0; cmd_wmask = '0;
      repeat (2) @(posedge clk);
      #1 chk_en = 1;
      @(negedge clk);
      chk("rst_cmd_ready", 64'(cmd_ready), 0);
      chk("rst_rsp_valid", 64'(rsp_valid), 0);
      chk("rst_rsp_err", 64'(rsp_err), 0);
      chk("rst_rsp_rdata", rsp_rdata, 0);
      chk("rst_holdup", 64'(holdup), 0);
      chk("rst_ram_cs", 64'(ram_cs), 0);
      @(posedge clk); #1;
      rst_n = 1; cmd_valid = 0;

      send(0, 17'h00000, DA, 8'hFF); get_rsp(d, e, lat);
      send(0, 17'h00008, DB, 8'hFF); get_rsp(d, e, lat);
      send(1, 17'h00000, 0, 0);      get_rsp(d, e, lat);
      chk("read0_rdata", d, DA);
      chk("read0_holdup", 64'(holdup), 1);

      send(0, 17'h00010, DC, 8'hFF); get_rsp(d, e, lat);
      chk("wr_rdata_zero", d, 0);
      chk("wr_holdup", 64'(holdup), 0);
      send(1, 17'h00010, 0, 0); get_rsp(d, e, lat);
      chk("rd_latency", 64'(lat), 0);
      chk("rd_rdata", d, DC);
      chk("rd_err", 64'(e), 0);
      chk("rd_holdup", 64'(holdup), 1);

      send(0, 17'h00010, 64'hFFFFFFFFAAAAAAAA, 8'h0F); get_rsp(d, e, lat);
      send(1, 17'h00010, 0, 0); get_rsp(d, e, lat);
      chk("partial_rdata", d, DP);

      // Back-to-back reads, one per cycle.
      cmd_valid = 1; cmd_read = 1; cmd_addr = 17'h00000;
      @(negedge clk); chk("b2b_rdy0", 64'(cmd_ready), 1);
      @(posedge clk); #1 cmd_addr = 17'h00008;
      @(negedge clk); chk("b2b_rdy1", 64'(cmd_ready), 1); chk("b2b_rsp0", rsp_rdata, DA);
      @(posedge clk); #1 cmd_addr = 17'h00010;
      @(negedge clk); chk("b2b_rdy2", 64'(cmd_ready), 1); chk("b2b_rsp1", rsp_rdata, DB);
      @(posedge clk); #1 cmd_valid = 0;
      @(negedge clk); chk("b2b_vld2", 64'(rsp_valid), 1); chk("b2b_rsp2", rsp_rdata, DP);
      @(posedge clk); #1;

      // Backpressure: response held for 5 cycles while the next command waits.
      rsp_ready = 0;
      send(1, 17'h00008, 0, 0);
      cmd_valid = 1; cmd_read = 1; cmd_addr = 17'h00000;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_valid", 64'(rsp_valid), 1);
         chk("bp_rdata", rsp_rdata, DB);
         chk("bp_cmd_ready", 64'(cmd_ready), 0);
         chk("bp_ram_cs", 64'(ram_cs), 0);
         @(posedge clk); #1;
      end
      rsp_ready = 1;
      @(negedge clk); chk("bp_release_rdy", 64'(cmd_ready), 1); chk("bp_release_cs", 64'(ram_cs), 1);
      @(posedge clk); #1 cmd_valid = 0;
      @(negedge clk); chk("bp_next_vld", 64'(rsp_valid), 1); chk("bp_next_rdata", rsp_rdata, DA);
      @(posedge clk); #1;

      // Out of range (word 8192) and the last in-range word.
      cmd_valid = 1; cmd_read = 1; cmd_addr = 17'h10000;
      @(negedge clk); chk("oor_rdy", 64'(cmd_ready), 1); chk("oor_ram_cs", 64'(ram_cs), 0);
      @(posedge clk); #1 cmd_valid = 0;
      get_rsp(d, e, lat);
      chk("oor_err", 64'(e), 1);
      chk("oor_rdata", d, 0);
      chk("oor_holdup", 64'(holdup), 1);
      send(0, 17'h10008, DC, 8'hFF); get_rsp(d, e, lat);
      chk("oor_wr_err", 64'(e), 1);
      chk("oor_wr_holdup", 64'(holdup), 1);
      send(0, 17'h0FFF8, DB, 8'hFF); get_rsp(d, e, lat);
      chk("last_wr_err", 64'(e), 0);
      send(1, 17'h0FFF8, 0, 0); get_rsp(d, e, lat);
      chk("last_rd_rdata", d, DB);
      chk("last_rd_err", 64'(e), 0);

      // Reset while a response is stalled.
      rsp_ready = 0;
      send(1, 17'h00010, 0, 0);
      rst_n = 0; cmd_valid = 1;
      @(negedge clk);
      chk("midrst_cmd_ready", 64'(cmd_ready), 0);
      chk("midrst_ram_cs", 64'(ram_cs), 0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("midrst_rsp_valid", 64'(rsp_valid), 0);
      chk("midrst_holdup", 64'(holdup), 0);
      chk("midrst_cmd_ready2", 64'(cmd_ready), 0);
      @(posedge clk); #1;
      rst_n = 1; cmd_valid = 0; rsp_ready = 1;
      send(1, 17'h00010, 0, 0); get_rsp(d, e, lat);
      chk("postrst_rdata", d, DP);
      chk("postrst_latency", 64'(lat), 0);

      repeat (2) @(posedge clk);
      chk_en = 0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
